// File: rtl/alu_muxes_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_muxes_if
// Purpose  : Bundles the ID/EX operand fields, the forwarding controls and the
//            combinational/registered results of the execute-stage operand
//            selection block.
// Revision : 1.0  initial release
// ============================================================================
interface alu_muxes_if;
  // Control fields from ID/EX and forwarding unit
  logic        RegDst;
  logic [2:0]  Rt;
  logic [2:0]  Rd;
  logic        ALUSrc;
  logic [1:0]  ForwardA;
  logic [1:0]  ForwardB;
  logic        Stall;

  // Data sources
  logic [15:0] Mem_ALUOut;
  logic [15:0] WB_WriteData;
  logic [15:0] ReadData1;
  logic [15:0] ReadData2;
  logic [15:0] Imm;

  // Combinational results
  logic [2:0]  DestReg;
  logic [15:0] Operand1;
  logic [15:0] Operand2;
  logic [15:0] StoreData;

  // EX/MEM boundary copies
  logic [2:0]  DestReg_q;
  logic [15:0] Operand1_q;
  logic [15:0] Operand2_q;
  logic [15:0] StoreData_q;

  // Pipeline side: supplies operands and controls, consumes results
  modport master (
    output RegDst, Rt, Rd, ALUSrc, ForwardA, ForwardB, Stall,
    output Mem_ALUOut, WB_WriteData, ReadData1, ReadData2, Imm,
    input  DestReg, Operand1, Operand2, StoreData,
    input  DestReg_q, Operand1_q, Operand2_q, StoreData_q
  );

  // Operand selection block side
  modport slave (
    input  RegDst, Rt, Rd, ALUSrc, ForwardA, ForwardB, Stall,
    input  Mem_ALUOut, WB_WriteData, ReadData1, ReadData2, Imm,
    output DestReg, Operand1, Operand2, StoreData,
    output DestReg_q, Operand1_q, Operand2_q, StoreData_q
  );
endinterface
`default_nettype wire

// File: rtl/alu_muxes.sv
`default_nettype none
// ============================================================================
// Module   : alu_muxes
// Purpose  : Execute-stage operand selection: forwarding muxes for operands
//            A and B, ALUSrc immediate mux, Rt/Rd destination mux, plus a
//            stallable, synchronously reset registered copy of each result.
// Revision : 1.0  initial release
// ============================================================================
module alu_muxes (
  input  wire logic  clk,
  input  wire logic  rst,
  alu_muxes_if.slave bus
);

  localparam logic [1:0] c_FWD_WB  = 2'b01;
  localparam logic [1:0] c_FWD_MEM = 2'b10;

  logic [15:0] w_fwd_a;
  logic [15:0] w_fwd_b;
  logic [15:0] w_operand2;
  logic [2:0]  w_dest_reg;

  logic [2:0]  r_dest_reg;
  logic [15:0] r_operand1;
  logic [15:0] r_operand2;
  logic [15:0] r_store_data;

  // Operand A forwarding; the reserved code 11 falls back to the register file
  always_comb begin
    w_fwd_a = bus.ReadData1;
    case (bus.ForwardA)
      c_FWD_WB:  w_fwd_a = bus.WB_WriteData;
      c_FWD_MEM: w_fwd_a = bus.Mem_ALUOut;
      default:   w_fwd_a = bus.ReadData1;
    endcase
  end

  // Operand B forwarding; this value is also the store data
  always_comb begin
    w_fwd_b = bus.ReadData2;
    case (bus.ForwardB)
      c_FWD_WB:  w_fwd_b = bus.WB_WriteData;
      c_FWD_MEM: w_fwd_b = bus.Mem_ALUOut;
      default:   w_fwd_b = bus.ReadData2;
    endcase
  end

  // Immediate vs forwarded B, and Rd vs Rt destination selection
  always_comb begin
    w_operand2 = bus.ALUSrc ? bus.Imm : w_fwd_b;
    w_dest_reg = bus.RegDst ? bus.Rd  : bus.Rt;
  end

  // EX/MEM copies: reset clears regardless of Stall, Stall holds
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dest_reg   <= 3'b000;
      r_operand1   <= 16'h0000;
      r_operand2   <= 16'h0000;
      r_store_data <= 16'h0000;
    end else if (!bus.Stall) begin
      r_dest_reg   <= w_dest_reg;
      r_operand1   <= w_fwd_a;
      r_operand2   <= w_operand2;
      r_store_data <= w_fwd_b;
    end
  end

  assign bus.DestReg     = w_dest_reg;
  assign bus.Operand1    = w_fwd_a;
  assign bus.Operand2    = w_operand2;
  assign bus.StoreData   = w_fwd_b;

  assign bus.DestReg_q   = r_dest_reg;
  assign bus.Operand1_q  = r_operand1;
  assign bus.Operand2_q  = r_operand2;
  assign bus.StoreData_q = r_store_data;

endmodule
`default_nettype wire

// File: tb/tb_alu_muxes.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_muxes
// Purpose  : Self-checking bench for alu_muxes: directed operand-selection
//            cases, registered path with stall and reset, and randomized
//            traffic against a table-driven reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_muxes;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_muxes_if bus ();

  alu_muxes dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Expected registered bundle {DestReg_q, Operand1_q, Operand2_q, StoreData_q}
  logic [50:0] exp_q;

  // Forward code -> source: 0 reg file, 1 write-back, 2 EX/MEM, 3 reg file
  function automatic logic [15:0] pick(input logic [1:0] code,
                                       input logic [15:0] rf,
                                       input logic [15:0] wb,
                                       input logic [15:0] mem);
    logic [15:0] src [4];
    src[0] = rf;
    src[1] = wb;
    src[2] = mem;
    src[3] = rf;
    return src[code];
  endfunction

  // Expected combinational bundle {DestReg, Operand1, Operand2, StoreData}
  function automatic logic [50:0] model_comb();
    logic [15:0] a;
    logic [15:0] b;
    a = pick(bus.ForwardA, bus.ReadData1, bus.WB_WriteData, bus.Mem_ALUOut);
    b = pick(bus.ForwardB, bus.ReadData2, bus.WB_WriteData, bus.Mem_ALUOut);
    return {(bus.RegDst ? bus.Rd : bus.Rt), a, (bus.ALUSrc ? bus.Imm : b), b};
  endfunction

  function automatic logic [50:0] obs_comb();
    return {bus.DestReg, bus.Operand1, bus.Operand2, bus.StoreData};
  endfunction

  function automatic logic [50:0] obs_q();
    return {bus.DestReg_q, bus.Operand1_q, bus.Operand2_q, bus.StoreData_q};
  endfunction

  task automatic set_common();
    bus.ReadData1    = 16'h1111;
    bus.ReadData2    = 16'h2222;
    bus.Mem_ALUOut   = 16'hAAAA;
    bus.WB_WriteData = 16'hBBBB;
    bus.Imm          = 16'hFFFF;
    bus.Rt           = 3'd1;
    bus.Rd           = 3'd2;
  endtask

  task automatic set_ctrl(input logic regdst, input logic alusrc,
                          input logic [1:0] fa, input logic [1:0] fb);
    bus.RegDst   = regdst;
    bus.ALUSrc   = alusrc;
    bus.ForwardA = fa;
    bus.ForwardB = fb;
    #1;
  endtask

  task automatic randomize_inputs();
    bus.RegDst       = 1'($urandom);
    bus.ALUSrc       = 1'($urandom);
    bus.ForwardA     = 2'($urandom);
    bus.ForwardB     = 2'($urandom);
    bus.Rt           = 3'($urandom);
    bus.Rd           = 3'($urandom);
    bus.ReadData1    = 16'($urandom);
    bus.ReadData2    = 16'($urandom);
    bus.Mem_ALUOut   = 16'($urandom);
    bus.WB_WriteData = 16'($urandom);
    bus.Imm          = 16'($urandom);
    #1;
  endtask

  // Advance one rising edge, updating the expected registered bundle
  task automatic tick();
    if (rst)            exp_q = '0;
    else if (!bus.Stall) exp_q = model_comb();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.Stall = 1'b0;
    randomize_inputs();
    tick();
    n_cmp++;
    if (obs_q() !== 51'h0) begin
      n_err++;
      $display("FAIL reset_q: got %h want %h", obs_q(), 51'h0);
    end
  endtask

  task automatic test_directed_comb();
    logic [50:0] want;
    logic [31:0] want_ab;
    rst = 1'b0;
    bus.Stall = 1'b0;
    set_common();

    set_ctrl(1'b0, 1'b0, 2'b00, 2'b00);
    want = {3'b001, 16'h1111, 16'h2222, 16'h2222};
    n_cmp++;
    if (obs_comb() !== want) begin
      n_err++;
      $display("FAIL plain_regs: got %h want %h", obs_comb(), want);
    end

    set_ctrl(1'b1, 1'b1, 2'b00, 2'b01);
    want = {3'b010, 16'h1111, 16'hFFFF, 16'hBBBB};
    n_cmp++;
    if (obs_comb() !== want) begin
      n_err++;
      $display("FAIL imm_rd: got %h want %h", obs_comb(), want);
    end

    set_ctrl(1'b0, 1'b0, 2'b10, 2'b01);
    want_ab = {16'hAAAA, 16'hBBBB};
    n_cmp++;
    if ({bus.Operand1, bus.Operand2} !== want_ab) begin
      n_err++;
      $display("FAIL fwd_mem_wb: got %h want %h", {bus.Operand1, bus.Operand2}, want_ab);
    end

    set_ctrl(1'b0, 1'b0, 2'b01, 2'b10);
    want_ab = {16'hBBBB, 16'hAAAA};
    n_cmp++;
    if ({bus.Operand1, bus.Operand2} !== want_ab) begin
      n_err++;
      $display("FAIL fwd_wb_mem: got %h want %h", {bus.Operand1, bus.Operand2}, want_ab);
    end

    set_ctrl(1'b0, 1'b0, 2'b11, 2'b11);
    want_ab = {16'h1111, 16'h2222};
    n_cmp++;
    if ({bus.Operand1, bus.Operand2} !== want_ab) begin
      n_err++;
      $display("FAIL fwd_reserved: got %h want %h", {bus.Operand1, bus.Operand2}, want_ab);
    end
  endtask

  task automatic test_registered_stall();
    logic [50:0] want;
    rst = 1'b0;
    bus.Stall = 1'b0;
    set_common();
    set_ctrl(1'b1, 1'b1, 2'b00, 2'b01);
    tick();
    want = {3'b010, 16'h1111, 16'hFFFF, 16'hBBBB};
    n_cmp++;
    if (obs_q() !== want) begin
      n_err++;
      $display("FAIL capture_q: got %h want %h", obs_q(), want);
    end

    bus.Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      randomize_inputs();
      tick();
      n_cmp++;
      if (obs_q() !== want) begin
        n_err++;
        $display("FAIL stall_hold_%0d: got %h want %h", i, obs_q(), want);
      end
    end

    // Release: the first edge captures the current combinational values
    bus.Stall = 1'b0;
    randomize_inputs();
    want = model_comb();
    tick();
    n_cmp++;
    if (obs_q() !== want) begin
      n_err++;
      $display("FAIL stall_release: got %h want %h", obs_q(), want);
    end

    rst = 1'b1;
    tick();
    n_cmp++;
    if (obs_q() !== 51'h0) begin
      n_err++;
      $display("FAIL reset_after_run: got %h want %h", obs_q(), 51'h0);
    end
    rst = 1'b0;
  endtask

  task automatic test_reset_over_stall();
    // Load something nonzero first so the clear is observable
    rst = 1'b0;
    bus.Stall = 1'b0;
    set_common();
    set_ctrl(1'b1, 1'b0, 2'b10, 2'b01);
    tick();
    rst = 1'b1;
    bus.Stall = 1'b1;
    tick();
    n_cmp++;
    if (obs_q() !== 51'h0) begin
      n_err++;
      $display("FAIL reset_over_stall_q: got %h want %h", obs_q(), 51'h0);
    end
    randomize_inputs();
    n_cmp++;
    if (obs_comb() !== model_comb()) begin
      n_err++;
      $display("FAIL comb_during_reset: got %h want %h", obs_comb(), model_comb());
    end
    rst = 1'b0;
    bus.Stall = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      rst       = ($urandom_range(0, 19) == 0);
      bus.Stall = 1'($urandom);
      randomize_inputs();
      n_cmp++;
      if (obs_comb() !== model_comb()) begin
        n_err++;
        $display("FAIL rand_comb_%0d: got %h want %h", i, obs_comb(), model_comb());
      end
      tick();
      n_cmp++;
      if (obs_q() !== exp_q) begin
        n_err++;
        $display("FAIL rand_q_%0d: got %h want %h", i, obs_q(), exp_q);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_back_to_back();
    // Consecutive unstalled edges each capture fresh values
    rst = 1'b0;
    bus.Stall = 1'b0;
    for (int i = 0; i < 8; i++) begin
      randomize_inputs();
      tick();
      n_cmp++;
      if (obs_q() !== exp_q) begin
        n_err++;
        $display("FAIL b2b_q_%0d: got %h want %h", i, obs_q(), exp_q);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.Stall = 1'b0;
    exp_q = '0;
    @(negedge clk);
    test_reset();
    test_directed_comb();
    test_registered_stall();
    test_reset_over_stall();
    test_random();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
